// File: rtl/irq_ctrl_pkg.sv
// Purpose : shared constants for the interrupt controller (register map, source bit indices).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package irq_ctrl_pkg;

    // CPU-visible register addresses
    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    // Interrupt source bit positions, lowest index = highest priority on the core side
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam int NUM_SRC_DEFAULT = 5;

endpackage

// File: rtl/irq_edge_det.sv
// Purpose : per-bit registered rising-edge detector for level interrupt requests.
// Latency : rise is combinational from req against last cycle's registered value.
// Backpressure: none; free-running every cycle.
// Ports   : clk, rst (sync, active-high), req[WIDTH] level inputs, rise[WIDTH] 0->1 indication.
module irq_edge_det #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        prev_d = req;
        rise   = req & ~prev_q;
    end

    // History clears to 0 so a line already high at reset release counts as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Purpose : interrupt flag (IF) / enable (IE) registers with edge-triggered request capture.
// Latency : request edge -> IF next cycle -> CPU_IRQ_TRIG/IRQ_ANY one cycle later; reads combinational.
// Backpressure: none; CPU bus accesses complete in a single cycle.
// Ports   : CLK, SYNC_RESET; IRQ_REQ level lines; CPU bus A/DIN/RD/WR/MMIO_REQ -> DOUT/DOE;
//           CPU_IRQ_ACK per-bit clears; CPU_IRQ_TRIG pending&enabled lines, IRQ_ANY wake.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT
) (
    input  logic               CLK,
    input  logic               SYNC_RESET,
    input  logic [NUM_SRC-1:0] IRQ_REQ,
    input  logic [15:0]        A,
    input  logic [7:0]         DIN,
    input  logic               RD,
    input  logic               WR,
    input  logic               MMIO_REQ,
    input  logic [7:0]         CPU_IRQ_ACK,
    output logic [7:0]         DOUT,
    output logic               DOE,
    output logic [7:0]         CPU_IRQ_TRIG,
    output logic               IRQ_ANY
);

    logic [NUM_SRC-1:0] if_q,   if_d;
    logic [7:0]         ie_q,   ie_d;
    logic [7:0]         trig_q, trig_d;

    logic [NUM_SRC-1:0] req_rise;
    logic [NUM_SRC-1:0] if_base;
    logic               hit_if, hit_ie;
    logic               wr_if,  wr_ie;
    logic [7:0]         if_rd_val;
    logic               unused_ack;

    irq_edge_det #(
        .WIDTH (NUM_SRC)
    ) u_edge_det (
        .clk  (CLK),
        .rst  (SYNC_RESET),
        .req  (IRQ_REQ),
        .rise (req_rise)
    );

    // Acknowledge lines above the implemented sources have no flag to clear.
    assign unused_ack = ^CPU_IRQ_ACK;

    always_comb begin
        hit_if = MMIO_REQ && (A == ADDR_IF);
        hit_ie = MMIO_REQ && (A == ADDR_IE);
        wr_if  = hit_if && WR;
        wr_ie  = hit_ie && WR;

        // Ordering of the terms sets priority: write < acknowledge < request edge.
        if_base = wr_if ? DIN[NUM_SRC-1:0] : if_q;
        if_d    = (if_base & ~CPU_IRQ_ACK[NUM_SRC-1:0]) | req_rise;

        ie_d = wr_ie ? DIN : ie_q;

        trig_d              = '0;
        trig_d[NUM_SRC-1:0] = if_q & ie_q[NUM_SRC-1:0];
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RESET) begin
            if_q   <= '0;
            ie_q   <= '0;
            trig_q <= '0;
        end else begin
            if_q   <= if_d;
            ie_q   <= ie_d;
            trig_q <= trig_d;
        end
    end

    // Read path shows current register state, so a simultaneous write reads back the old value.
    always_comb begin
        if_rd_val              = 8'hFF;
        if_rd_val[NUM_SRC-1:0] = if_q;

        DOE  = RD && (hit_if || hit_ie);
        DOUT = 8'h00;
        if (DOE) begin
            DOUT = hit_if ? if_rd_val : ie_q;
        end
    end

    assign CPU_IRQ_TRIG = trig_q;
    assign IRQ_ANY      = |trig_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam int NSRC = 5;

    logic            CLK = 1'b0;
    logic            SYNC_RESET;
    logic [NSRC-1:0] IRQ_REQ;
    logic [15:0]     A;
    logic [7:0]      DIN;
    logic            RD;
    logic            WR;
    logic            MMIO_REQ;
    logic [7:0]      CPU_IRQ_ACK;
    logic [7:0]      DOUT;
    logic            DOE;
    logic [7:0]      CPU_IRQ_TRIG;
    logic            IRQ_ANY;

    irq_ctrl #(.NUM_SRC(NSRC)) dut (
        .CLK          (CLK),
        .SYNC_RESET   (SYNC_RESET),
        .IRQ_REQ      (IRQ_REQ),
        .A            (A),
        .DIN          (DIN),
        .RD           (RD),
        .WR           (WR),
        .MMIO_REQ     (MMIO_REQ),
        .CPU_IRQ_ACK  (CPU_IRQ_ACK),
        .DOUT         (DOUT),
        .DOE          (DOE),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
        .IRQ_ANY      (IRQ_ANY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_val(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check_obs(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge, away from sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        A = addr; DIN = data; MMIO_REQ = 1'b1; WR = 1'b1;
        step();
        WR = 1'b0; MMIO_REQ = 1'b0; A = 16'h0000; DIN = 8'h00;
    endtask

    // Combinational read between edges; no clock is consumed.
    task automatic bus_read(input logic [15:0] addr, input logic mmio,
                            output logic [7:0] data, output logic oe);
        A = addr; MMIO_REQ = mmio; RD = 1'b1;
        #1;
        data = DOUT;
        oe   = DOE;
        RD = 1'b0; MMIO_REQ = 1'b0; A = 16'h0000;
        #1;
    endtask

    logic [7:0] rd;
    logic       oe;

    initial begin
        SYNC_RESET = 1'b1; IRQ_REQ = '0; A = '0; DIN = '0;
        RD = 1'b0; WR = 1'b0; MMIO_REQ = 1'b0; CPU_IRQ_ACK = '0;
        step();
        step();
        SYNC_RESET = 1'b0;

        // Reset state
        expect_val("rst_trig", 8'h00); check_obs(CPU_IRQ_TRIG);
        expect_val("rst_any",  8'h00); check_obs({7'd0, IRQ_ANY});
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("rst_if_read", 8'hE0); check_obs(rd);
        bus_read(16'hFFFF, 1'b1, rd, oe);
        expect_val("rst_ie_read", 8'h00); check_obs(rd);
        expect_val("idle_doe", 8'h00); check_obs({7'd0, DOE});

        // VBlank edge: IF next cycle, TRIG one cycle after that
        bus_write(16'hFFFF, 8'h01);
        IRQ_REQ = 5'b00001;
        step();
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("vbl_if_n1", 8'hE1);   check_obs(rd);
        expect_val("vbl_trig_n1", 8'h00); check_obs(CPU_IRQ_TRIG);
        step();
        expect_val("vbl_trig_n2", 8'h01); check_obs(CPU_IRQ_TRIG);
        expect_val("vbl_any_n2", 8'h01);  check_obs({7'd0, IRQ_ANY});

        // Acknowledge clears; held line does not re-set
        CPU_IRQ_ACK = 8'h01;
        step();
        CPU_IRQ_ACK = 8'h00;
        step();
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("ack_if_held", 8'hE0); check_obs(rd);
        expect_val("ack_trig", 8'h00);    check_obs(CPU_IRQ_TRIG);

        // Timer flag acknowledged
        bus_write(16'hFFFF, 8'h04);
        bus_write(16'hFF0F, 8'h04);
        step();
        expect_val("tmr_trig_set", 8'h04); check_obs(CPU_IRQ_TRIG);
        CPU_IRQ_ACK = 8'h04;
        step();
        CPU_IRQ_ACK = 8'h00;
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("tmr_if_acked", 8'hE0);   check_obs(rd);
        expect_val("tmr_trig_lag", 8'h04);   check_obs(CPU_IRQ_TRIG);
        step();
        expect_val("tmr_trig_clear", 8'h00); check_obs(CPU_IRQ_TRIG);

        // Edge beats acknowledge and a clearing write in the same cycle
        IRQ_REQ = 5'b00101;
        CPU_IRQ_ACK = 8'h04;
        bus_write(16'hFF0F, 8'h00);
        CPU_IRQ_ACK = 8'h00;
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("edge_wins", 8'hE4); check_obs(rd);

        // Acknowledge beats a setting write
        CPU_IRQ_ACK = 8'h02;
        bus_write(16'hFF0F, 8'h02);
        CPU_IRQ_ACK = 8'h00;
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("ack_beats_wr", 8'hE0); check_obs(rd);

        // Acknowledge bits above the source count are ignored
        bus_write(16'hFF0F, 8'h1F);
        CPU_IRQ_ACK = 8'hE0;
        step();
        CPU_IRQ_ACK = 8'h00;
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("ack_high_ignored", 8'hFF); check_obs(rd);

        // All sources pending with IE=0, then enable Joypad only
        bus_write(16'hFFFF, 8'h00);
        IRQ_REQ = '0;
        bus_write(16'hFF0F, 8'h00);
        IRQ_REQ = 5'b11111;
        step();
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("all_if", 8'hFF); check_obs(rd);
        step();
        expect_val("all_trig_masked", 8'h00); check_obs(CPU_IRQ_TRIG);
        bus_write(16'hFFFF, 8'h10);
        expect_val("joy_trig_wr_cycle", 8'h00); check_obs(CPU_IRQ_TRIG);
        step();
        expect_val("joy_trig", 8'h10); check_obs(CPU_IRQ_TRIG);
        expect_val("joy_any", 8'h01);  check_obs({7'd0, IRQ_ANY});

        // STAT held high 20 cycles, flags cleared by a write at cycle 5
        IRQ_REQ = '0;
        step();
        IRQ_REQ = 5'b00010;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus_write(16'hFF0F, 8'h00);
            end else begin
                step();
            end
        end
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("stat_held_if", 8'hE0); check_obs(rd);
        bus_read(16'hFFFF, 1'b0, rd, oe);
        expect_val("no_mmio_doe", 8'h00);  check_obs({7'd0, oe});
        expect_val("no_mmio_dout", 8'h00); check_obs(rd);
        bus_read(16'hFF10, 1'b1, rd, oe);
        expect_val("bad_addr_doe", 8'h00); check_obs({7'd0, oe});

        // Read and write together: old value on the bus, new value stored
        A = 16'hFFFF; MMIO_REQ = 1'b1; RD = 1'b1; WR = 1'b1; DIN = 8'h3C;
        #1;
        expect_val("rdwr_doe", 8'h01);      check_obs({7'd0, DOE});
        expect_val("rdwr_old_val", 8'h10);  check_obs(DOUT);
        step();
        RD = 1'b0; WR = 1'b0; MMIO_REQ = 1'b0; A = '0; DIN = '0;
        bus_read(16'hFFFF, 1'b1, rd, oe);
        expect_val("rdwr_new_val", 8'h3C);  check_obs(rd);

        // Reset mid-request discards everything; held lines re-register after release
        bus_write(16'hFFFF, 8'hFF);
        bus_write(16'hFF0F, 8'h1F);
        step();
        expect_val("pre_rst_trig", 8'h1F); check_obs(CPU_IRQ_TRIG);
        IRQ_REQ = 5'b11111;
        SYNC_RESET = 1'b1;
        step();
        expect_val("rst_mid_trig", 8'h00); check_obs(CPU_IRQ_TRIG);
        expect_val("rst_mid_any", 8'h00);  check_obs({7'd0, IRQ_ANY});
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("rst_mid_if", 8'hE0);   check_obs(rd);
        CPU_IRQ_ACK = 8'hFF;
        bus_write(16'hFFFF, 8'h55);
        CPU_IRQ_ACK = 8'h00;
        bus_read(16'hFFFF, 1'b1, rd, oe);
        expect_val("rst_wr_ignored", 8'h00); check_obs(rd);
        SYNC_RESET = 1'b0;
        step();
        bus_read(16'hFF0F, 1'b1, rd, oe);
        expect_val("post_rst_edge_if", 8'hFF); check_obs(rd);
        expect_val("post_rst_trig", 8'h00);    check_obs(CPU_IRQ_TRIG);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
